// File: rtl/fb_pixel_loader_pkg.sv
// Shared types and constants for the frame-buffer pixel loader and the panel side.
// Pixel layout is {R[3:0], G[3:0], B[3:0]}; two pixels are packed into three bytes.
package fb_pixel_loader_pkg;

    localparam int unsigned PIX_W_DEF     = 12;
    localparam int unsigned ADDR_W_DEF    = 12;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StB0,
        StB1,
        StB2,
        StDone
    } state_e;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    function automatic logic [3:0] pix_red(input pixel_t p);
        return p[11:8];
    endfunction

    function automatic logic [3:0] pix_green(input pixel_t p);
        return p[7:4];
    endfunction

    function automatic logic [3:0] pix_blue(input pixel_t p);
        return p[3:0];
    endfunction

    // First pixel of a triplet: whole first byte plus high nibble of the second.
    function automatic pixel_t pack_pix0(input logic [7:0] hold, input logic [7:0] b);
        return {hold, b[7:4]};
    endfunction

    // Second pixel: low nibble of the second byte plus the whole third byte.
    function automatic pixel_t pack_pix1(input logic [3:0] nib, input logic [7:0] b);
        return {nib, b};
    endfunction

endpackage

// File: rtl/fb_byte_timeout.sv
// Inter-byte idle counter: clears on every accepted byte and pulses expired_o
// once TIMEOUT consecutive idle cycles have elapsed while counting is enabled.
module fb_byte_timeout #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        expired_o = count_en_i && !clear_i && (cnt_q == CntW'(TIMEOUT - 1));
        if (clear_i || !count_en_i || expired_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fb_pixel_loader.sv
// Byte-stream to frame-memory loader: waits for a sync byte, then unpacks
// 2 pixels per 3 bytes into sequential 12bpp writes and flags frame end/abort.
module fb_pixel_loader
    import fb_pixel_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned PIX_W     = PIX_W_DEF,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout
);

    localparam logic [ADDR_W-1:0] LastAddr = '1;

    state_e            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic [3:0]        nib_q, nib_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [ADDR_W-1:0] pix_inc;

    logic              rx_ready_q, rx_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              err_timeout_q, err_timeout_d;

    logic              accept;
    logic              in_frame;
    logic              expired;

    assign accept   = rx_valid && rx_ready_q;
    assign in_frame = (state_q == StB0) || (state_q == StB1) || (state_q == StB2);
    assign pix_inc  = pix_q + ADDR_W'(1);

    fb_byte_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (accept),
        .count_en_i (in_frame),
        .expired_o  (expired)
    );

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        nib_d         = nib_q;
        pix_d         = pix_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = StB0;
                    pix_d   = '0;
                end
            end
            StB0: begin
                if (accept) begin
                    hold_d  = rx_data;
                    state_d = StB1;
                end
            end
            StB1: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_q;
                    wr_data_d = pack_pix0(hold_q, rx_data);
                    nib_d     = rx_data[3:0];
                    state_d   = StB2;
                end
            end
            StB2: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_inc;
                    wr_data_d = pack_pix1(nib_q, rx_data);
                    if (pix_inc == LastAddr) begin
                        frame_done_d = 1'b1;
                        pix_d        = '0;
                        state_d      = StDone;
                    end else begin
                        pix_d   = pix_inc + ADDR_W'(1);
                        state_d = StB0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Expiry only fires on cycles without an accepted byte, so no write is lost here.
        if (expired) begin
            state_d       = StIdle;
            err_timeout_d = 1'b1;
        end

        rx_ready_d = (state_d != StDone);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            nib_q         <= '0;
            pix_q         <= '0;
            rx_ready_q    <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            nib_q         <= nib_d;
            pix_q         <= pix_d;
            rx_ready_q    <= rx_ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_timeout_q;

endmodule
